dbg_program_loader: RTL and testbench
=====================================

// Module: dbg_program_loader
// PURPOSE
// Debug-port initiator that loads a program image into cpuCore through its dbg_wr_en/dbg_addr/dbg_instr
// write interface. Consumes a byte stream (e.g. from a UART receiver), assembles little-endian XLEN words
// and issues one debug write per word. Holds the core in reset during loading and releases it afterwards.
// Sits between the host byte link and cpuCore (drives the core's rst and dbg_* inputs).
// PARAMETERS
// XLEN       32     data/address width of the debug port (fixed 32; 4 bytes per word)
// BASE_ADDR  0      dbg_addr of the first word
// ADDR_STEP  4      dbg_addr increment per word
// MAX_WORDS  1024   largest accepted word count; larger counts are an error
// PORTS
// clk         in   1     system clock
// rst         in   1     synchronous active-high reset
// start       in   1     1-cycle pulse: begin a load; honoured only in IDLE or ERROR
// byte_valid  in   1     byte_data is valid
// byte_data   in   8     stream byte
// byte_ready  out  1     loader accepts byte_data this cycle (transfer = byte_valid & byte_ready)
// dbg_wr_en   out  1     debug write strobe to cpuCore, 1 cycle per word
// dbg_addr    out  XLEN  debug write address
// dbg_instr   out  XLEN  debug write data
// cpu_rst     out  1     reset to cpuCore, 1 = core held in reset
// busy        out  1     load in progress (any state except IDLE/ERROR)
// done        out  1     1-cycle pulse when the core is released
// err         out  1     word count exceeded MAX_WORDS; high while in ERROR
// BEHAVIOUR
// - All outputs registered. Reset values: cpu_rst=1, dbg_wr_en=0, dbg_addr=0, dbg_instr=0, byte_ready=0,
//   busy=0, done=0, err=0; state=IDLE. cpu_rst stays 1 after reset until the first successful load.
// - Frame: count_lo, count_hi (16-bit word count N, LE), then N x 4 bytes, each word LE (byte0 = bits 7:0).
// - States: IDLE -> CNT_LO -> CNT_HI -> {BYTE -> WRITE}xN -> RELEASE -> IDLE; CNT_HI -> ERROR.
//   IDLE: byte_ready=0; start -> CNT_LO, cpu_rst<=1, busy<=1, word index k<=0.
//   CNT_LO/CNT_HI: byte_ready=1; each accepted byte fills the count. After CNT_HI: N=0 -> RELEASE;
//   N>MAX_WORDS -> ERROR; else -> BYTE with byte index 0.
//   BYTE: byte_ready=1; byte i fills word[8i+7:8i]; after the 4th accepted byte -> WRITE.
//   WRITE (1 cycle): byte_ready=0; dbg_wr_en=1, dbg_addr=BASE_ADDR+ADDR_STEP*k (mod 2^XLEN),
//   dbg_instr=assembled word, both stable while dbg_wr_en=1. k<=k+1; k==N-1 -> RELEASE, else -> BYTE.
//   RELEASE (1 cycle): cpu_rst=1 still (at least one reset cycle after the last write); next cycle
//   cpu_rst<=0, done=1 for 1 cycle, busy<=0, state IDLE.
//   ERROR: err=1, cpu_rst=1, byte_ready=0, no writes; start -> CNT_LO with err<=0.
// - Ordering: a write address/data is never driven together with cpu_rst=0; the final dbg_wr_en pulse is
//   followed by exactly one more cpu_rst=1 cycle (RELEASE), then cpu_rst=0 in the same cycle done=1.
// - Bubbles: byte_valid gaps stall the FSM indefinitely (no timeout); bytes presented while byte_ready=0
//   are not consumed. One non-accepting cycle per word (WRITE).
// - dbg_addr/dbg_instr keep the last written values between strobes; dbg_wr_en is 0 outside WRITE.
// - start while busy is ignored. start in IDLE after a completed load re-asserts cpu_rst (reload).
// - rst in any state (including mid-word): all outputs and state to reset values next cycle; the partial
//   word is discarded and not written; a following start begins a fresh frame.
// TESTING
// 1 Reset: rst=1 for 2 cycles -> cpu_rst=1, dbg_wr_en=0, byte_ready=0, busy=0, done=0, err=0.
// 2 Single word: start; bytes 01 00 93 00 A0 0E -> one dbg_wr_en pulse, addr 0, instr 32'h0EA00093;
//   cpu_rst=1 one more cycle, then cpu_rst=0 with done=1.
// 3 Three words with random byte_valid gaps -> writes at addr 0,4,8 in order, data matches, one pulse
//   each, byte_ready=0 in each WRITE cycle, no byte lost or duplicated.
// 4 N=0: start; bytes 00 00 -> no dbg_wr_en, done pulse, cpu_rst falls.
// 5 N=MAX_WORDS+1 -> err=1, cpu_rst=1, byte_ready=0, no writes; start then valid 1-word frame -> err=0, load OK.
// 6 rst after 2 bytes of word 1 -> no write, reset values; fresh 1-word load then writes addr 0 correctly.

Source files
------------

// File: rtl/dbg_program_loader.sv
// Debug-port program loader: turns a framed byte stream into cpuCore debug
// writes, holding the core in reset while the image is being loaded.
module dbg_program_loader #(
    parameter int unsigned          XLEN      = 32,
    parameter logic [XLEN-1:0]      BASE_ADDR = '0,
    parameter logic [XLEN-1:0]      ADDR_STEP = 4,
    parameter int unsigned          MAX_WORDS = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            byte_valid,
    input  logic [7:0]      byte_data,
    output logic            byte_ready,
    output logic            dbg_wr_en,
    output logic [XLEN-1:0] dbg_addr,
    output logic [XLEN-1:0] dbg_instr,
    output logic            cpu_rst,
    output logic            busy,
    output logic            done,
    output logic            err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_LO,
        S_CNT_HI,
        S_BYTE,
        S_WRITE,
        S_RELEASE,
        S_ERROR
    } state_t;

    state_t            state;
    state_t            next_state;

    logic [15:0]       count;
    logic [15:0]       k;
    logic [1:0]        byte_idx;
    logic [23:0]       word_lo;
    logic [XLEN-1:0]   addr_nxt;

    logic              acc;
    logic              start_ok;
    logic [15:0]       n_in;
    logic              n_zero;
    logic              n_over;
    logic              last_word;

    // A byte moves only when the loader is in an accepting state.
    assign acc       = byte_valid & byte_ready;
    assign start_ok  = start & ((state == S_IDLE) | (state == S_ERROR));
    // Word count as it will be once the high byte lands this cycle.
    assign n_in      = {byte_data, count[7:0]};
    assign n_zero    = (n_in == 16'd0);
    assign n_over    = ({16'd0, n_in} > MAX_WORDS);
    assign last_word = ((k + 16'd1) == count);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Frame sequencing: count, then {4 bytes, 1 write} per word, then release.
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                if (acc) begin
                    next_state = S_CNT_HI;
                end
            end
            S_CNT_HI: begin
                if (acc) begin
                    if (n_zero) begin
                        next_state = S_RELEASE;
                    end else if (n_over) begin
                        next_state = S_ERROR;
                    end else begin
                        next_state = S_BYTE;
                    end
                end
            end
            S_BYTE: begin
                if (acc && (byte_idx == 2'd3)) begin
                    next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                if (last_word) begin
                    next_state = S_RELEASE;
                end else begin
                    next_state = S_BYTE;
                end
            end
            S_RELEASE: begin
                next_state = S_IDLE;
            end
            S_ERROR: begin
                if (start) begin
                    next_state = S_CNT_LO;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Count capture, word assembly, word index and running write address.
    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            k        <= '0;
            byte_idx <= '0;
            word_lo  <= '0;
            addr_nxt <= BASE_ADDR;
        end else begin
            if (start_ok) begin
                k        <= '0;
                byte_idx <= '0;
                addr_nxt <= BASE_ADDR;
            end
            if ((state == S_CNT_LO) && acc) begin
                count[7:0] <= byte_data;
            end
            if ((state == S_CNT_HI) && acc) begin
                count[15:8] <= byte_data;
                byte_idx    <= '0;
            end
            if ((state == S_BYTE) && acc) begin
                unique case (byte_idx)
                    2'd0:    word_lo[7:0]   <= byte_data;
                    2'd1:    word_lo[15:8]  <= byte_data;
                    2'd2:    word_lo[23:16] <= byte_data;
                    default: word_lo        <= word_lo;
                endcase
                byte_idx <= byte_idx + 2'd1;
            end
            if (state == S_WRITE) begin
                k        <= k + 16'd1;
                addr_nxt <= addr_nxt + ADDR_STEP;
            end
        end
    end

    // Registered outputs, decoded from the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_ready <= 1'b0;
            dbg_wr_en  <= 1'b0;
            dbg_addr   <= '0;
            dbg_instr  <= '0;
            cpu_rst    <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            byte_ready <= (next_state == S_CNT_LO) |
                          (next_state == S_CNT_HI) |
                          (next_state == S_BYTE);
            busy       <= (next_state != S_IDLE) &
                          (next_state != S_ERROR);
            err        <= (next_state == S_ERROR);
            done       <= (state == S_RELEASE);
            dbg_wr_en  <= (next_state == S_WRITE);
            if (next_state == S_WRITE) begin
                dbg_addr  <= addr_nxt;
                dbg_instr <= {byte_data, word_lo};
            end
            // The core leaves reset only on the cycle after RELEASE.
            if (state == S_RELEASE) begin
                cpu_rst <= 1'b0;
            end else if (start_ok) begin
                cpu_rst <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dbg_program_loader.sv
// Self-checking bench for dbg_program_loader: a scoreboard of expected
// debug writes is filled as frames are sent and drained by a write monitor.
module tb_dbg_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        dbg_wr_en;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_instr;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;

    int vecs = 0;
    int errs = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int last_wr_cyc = 0;
    int done_cyc = 0;
    logic prev_rst = 1'b1;
    logic done_prev_rst = 1'b0;
    logic [63:0] exp_q[$];

    dbg_program_loader dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .byte_valid(byte_valid),
        .byte_data(byte_data),
        .byte_ready(byte_ready),
        .dbg_wr_en(dbg_wr_en),
        .dbg_addr(dbg_addr),
        .dbg_instr(dbg_instr),
        .cpu_rst(cpu_rst),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    // Write monitor: pops the scoreboard on every debug strobe.
    always @(negedge clk) begin
        logic [63:0] e;
        cyc++;
        if (dbg_wr_en === 1'b1) begin
            wr_cnt++;
            last_wr_cyc = cyc;
            vecs++;
            if (exp_q.size() == 0) begin
                errs++;
                $display("FAIL unexpected_write got addr=%h data=%h, none expected",
                         dbg_addr, dbg_instr);
            end else begin
                e = exp_q.pop_front();
                if ({dbg_addr, dbg_instr} !== e) begin
                    errs++;
                    $display("FAIL write got addr=%h data=%h exp addr=%h data=%h",
                             dbg_addr, dbg_instr, e[63:32], e[31:0]);
                end
            end
            vecs++;
            if (byte_ready !== 1'b0) begin
                errs++;
                $display("FAIL ready_in_write got %b exp 0", byte_ready);
            end
            vecs++;
            if (cpu_rst !== 1'b1) begin
                errs++;
                $display("FAIL rst_in_write got %b exp 1", cpu_rst);
            end
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            done_prev_rst = prev_rst;
        end
        prev_rst = cpu_rst;
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        int g = 0;
        if (gap > 0) g = int'($urandom_range(gap, 0));
        repeat (g) begin
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (byte_ready !== 1'b1) begin
            vecs++;
            errs++;
            $display("FAIL byte_timeout got ready=%b exp 1", byte_ready);
        end
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], gap);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        int t = 0;
        ok = 1'b0;
        while (t < 300) begin
            @(negedge clk);
            #1;
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            t++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vecs++; if (cpu_rst !== 1'b1) begin errs++; $display("FAIL reset_cpu_rst got %b exp 1", cpu_rst); end
        vecs++; if (dbg_wr_en !== 1'b0) begin errs++; $display("FAIL reset_wr_en got %b exp 0", dbg_wr_en); end
        vecs++; if (byte_ready !== 1'b0) begin errs++; $display("FAIL reset_ready got %b exp 0", byte_ready); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b exp 0", busy); end
        vecs++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done got %b exp 0", done); end
        vecs++; if (err !== 1'b0) begin errs++; $display("FAIL reset_err got %b exp 0", err); end
        vecs++; if (dbg_addr !== 32'h0) begin errs++; $display("FAIL reset_addr got %h exp 0", dbg_addr); end
        vecs++; if (dbg_instr !== 32'h0) begin errs++; $display("FAIL reset_instr got %h exp 0", dbg_instr); end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        int base = wr_cnt;
        bit ok;
        exp_q.push_back({32'h0, 32'h0EA00093});
        pulse_start();
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL single_busy got %b exp 1", busy); end
        vecs++; if (byte_ready !== 1'b1) begin errs++; $display("FAIL single_ready got %b exp 1", byte_ready); end
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_word(32'h0EA00093, 0);
        wait_done(ok);
        vecs++; if (!ok) begin errs++; $display("FAIL single_done got timeout exp done"); end
        vecs++; if (cpu_rst !== 1'b0) begin errs++; $display("FAIL single_rel got %b exp 0", cpu_rst); end
        vecs++; if (done_cyc - last_wr_cyc != 2) begin errs++; $display("FAIL single_gap got %0d exp 2", done_cyc - last_wr_cyc); end
        vecs++; if (done_prev_rst !== 1'b1) begin errs++; $display("FAIL single_release_rst got %b exp 1", done_prev_rst); end
        vecs++; if (wr_cnt - base != 1) begin errs++; $display("FAIL single_count got %0d exp 1", wr_cnt - base); end
        @(posedge clk);
        #1;
        vecs++; if (done !== 1'b0) begin errs++; $display("FAIL single_done_pulse got %b exp 0", done); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL single_idle_busy got %b exp 0", busy); end
        vecs++; if (cpu_rst !== 1'b0) begin errs++; $display("FAIL single_run got %b exp 0", cpu_rst); end
    endtask

    task automatic test_three();
        int base = wr_cnt;
        bit ok;
        logic [31:0] w [3];
        for (int i = 0; i < 3; i++) begin
            w[i] = $urandom;
            exp_q.push_back({32'(i * 4), w[i]});
        end
        pulse_start();
        vecs++; if (cpu_rst !== 1'b1) begin errs++; $display("FAIL three_reload got %b exp 1", cpu_rst); end
        send_byte(8'h03, 3);
        send_byte(8'h00, 3);
        for (int i = 0; i < 3; i++) begin
            send_word(w[i], 3);
        end
        wait_done(ok);
        vecs++; if (!ok) begin errs++; $display("FAIL three_done got timeout exp done"); end
        vecs++; if (wr_cnt - base != 3) begin errs++; $display("FAIL three_count got %0d exp 3", wr_cnt - base); end
        vecs++; if (exp_q.size() != 0) begin errs++; $display("FAIL three_left got %0d exp 0", exp_q.size()); end
        vecs++; if (done_prev_rst !== 1'b1) begin errs++; $display("FAIL three_release_rst got %b exp 1", done_prev_rst); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_rst_mid();
        int base = wr_cnt;
        bit ok;
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        vecs++; if (byte_ready !== 1'b0) begin errs++; $display("FAIL mid_ready got %b exp 0", byte_ready); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL mid_busy got %b exp 0", busy); end
        vecs++; if (cpu_rst !== 1'b1) begin errs++; $display("FAIL mid_cpu_rst got %b exp 1", cpu_rst); end
        vecs++; if (dbg_addr !== 32'h0) begin errs++; $display("FAIL mid_addr got %h exp 0", dbg_addr); end
        vecs++; if (dbg_instr !== 32'h0) begin errs++; $display("FAIL mid_instr got %h exp 0", dbg_instr); end
        repeat (4) @(posedge clk);
        #1;
        vecs++; if (wr_cnt != base) begin errs++; $display("FAIL mid_nowrite got %0d exp %0d", wr_cnt, base); end
        exp_q.push_back({32'h0, 32'hDEADBEEF});
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_word(32'hDEADBEEF, 1);
        wait_done(ok);
        vecs++; if (!ok) begin errs++; $display("FAIL mid_done got timeout exp done"); end
        vecs++; if (wr_cnt - base != 1) begin errs++; $display("FAIL mid_count got %0d exp 1", wr_cnt - base); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_zero();
        int base = wr_cnt;
        int d0 = done_cnt;
        bit ok;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        wait_done(ok);
        vecs++; if (!ok) begin errs++; $display("FAIL zero_done got timeout exp done"); end
        vecs++; if (cpu_rst !== 1'b0) begin errs++; $display("FAIL zero_rel got %b exp 0", cpu_rst); end
        vecs++; if (wr_cnt != base) begin errs++; $display("FAIL zero_nowrite got %0d exp %0d", wr_cnt, base); end
        vecs++; if (done_cnt - d0 != 1) begin errs++; $display("FAIL zero_pulses got %0d exp 1", done_cnt - d0); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_max();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        vecs++; if (err !== 1'b0) begin errs++; $display("FAIL max_err got %b exp 0", err); end
        vecs++; if (byte_ready !== 1'b1) begin errs++; $display("FAIL max_ready got %b exp 1", byte_ready); end
        vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL max_busy got %b exp 1", busy); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_error();
        int base = wr_cnt;
        bit ok;
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        vecs++; if (err !== 1'b1) begin errs++; $display("FAIL err_flag got %b exp 1", err); end
        vecs++; if (cpu_rst !== 1'b1) begin errs++; $display("FAIL err_cpu_rst got %b exp 1", cpu_rst); end
        vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL err_busy got %b exp 0", busy); end
        byte_valid = 1'b1;
        byte_data  = 8'hAA;
        repeat (5) @(posedge clk);
        #1;
        vecs++; if (byte_ready !== 1'b0) begin errs++; $display("FAIL err_ready got %b exp 0", byte_ready); end
        vecs++; if (err !== 1'b1) begin errs++; $display("FAIL err_hold got %b exp 1", err); end
        byte_valid = 1'b0;
        vecs++; if (wr_cnt != base) begin errs++; $display("FAIL err_nowrite got %0d exp %0d", wr_cnt, base); end
        exp_q.push_back({32'h0, 32'h12345678});
        pulse_start();
        vecs++; if (err !== 1'b0) begin errs++; $display("FAIL err_clear got %b exp 0", err); end
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_word(32'h12345678, 0);
        wait_done(ok);
        vecs++; if (!ok) begin errs++; $display("FAIL err_reload got timeout exp done"); end
        vecs++; if (cpu_rst !== 1'b0) begin errs++; $display("FAIL err_rel got %b exp 0", cpu_rst); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_start_busy();
        int base = wr_cnt;
        bit ok;
        exp_q.push_back({32'h0, 32'hA5C3_0F11});
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        pulse_start();
        send_byte(8'h0F, 0);
        send_byte(8'hC3, 0);
        send_byte(8'hA5, 0);
        wait_done(ok);
        vecs++; if (!ok) begin errs++; $display("FAIL busy_done got timeout exp done"); end
        vecs++; if (wr_cnt - base != 1) begin errs++; $display("FAIL busy_count got %0d exp 1", wr_cnt - base); end
        vecs++; if (exp_q.size() != 0) begin errs++; $display("FAIL busy_left got %0d exp 0", exp_q.size()); end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        test_reset();
        test_single();
        test_three();
        test_rst_mid();
        test_zero();
        test_max();
        test_error();
        test_start_busy();
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
